// File: rtl/tim_arbiter.sv
// tim_arbiter: merges the fetch and load/store ports onto the single-issue TIM port,
// buffering one losing request per port and steering each response back to its issuer.
module tim_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        tim_valid,
    output logic        tim_instr,
    output logic [31:0] tim_addr,
    output logic [31:0] tim_wdata,
    output logic [3:0]  tim_wstrb,
    input  logic [31:0] tim_rdata,
    input  logic        tim_ready
);
    logic        pend_i, pend_d, last_d, owner_valid, owner_id;
    logic [67:0] buf_i, buf_d, pl_i, pl_d;
    logic        cand_i, cand_d, grant_i, grant_d, route_i, route_d;

    always_comb begin
        pl_i    = pend_i ? buf_i : {imem_addr, imem_wdata, imem_wstrb};
        pl_d    = pend_d ? buf_d : {dmem_addr, dmem_wdata, dmem_wstrb};
        cand_i  = pend_i | imem_valid;
        cand_d  = pend_d | dmem_valid;
        // last_d=0 means imem was granted last, so a tie goes to dmem
        grant_d = reset & cand_d & (~cand_i | ~last_d);
        grant_i = reset & cand_i & ~grant_d;
        route_i = reset & owner_valid & owner_id;
        route_d = reset & owner_valid & ~owner_id;
    end

    assign tim_valid = grant_i | grant_d;
    assign tim_instr = grant_i;
    assign {tim_addr, tim_wdata, tim_wstrb} = grant_i ? pl_i : grant_d ? pl_d : 68'd0;
    assign imem_ready = route_i & tim_ready;
    assign dmem_ready = route_d & tim_ready;
    assign imem_rdata = route_i ? tim_rdata : 32'd0;
    assign dmem_rdata = route_d ? tim_rdata : 32'd0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_i      <= 1'b0;
            pend_d      <= 1'b0;
            last_d      <= 1'b0;
            owner_valid <= 1'b0;
            owner_id    <= 1'b0;
        end else begin
            pend_i      <= cand_i & ~grant_i;
            pend_d      <= cand_d & ~grant_d;
            owner_valid <= tim_valid;
            if (tim_valid) begin
                owner_id <= grant_i;
                last_d   <= grant_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!pend_i) buf_i <= {imem_addr, imem_wdata, imem_wstrb};
        if (!pend_d) buf_d <= {dmem_addr, dmem_wdata, dmem_wstrb};
    end
endmodule

// File: tb/tb_tim_arbiter.sv
// tb_tim_arbiter: directed checks of tim_arbiter against a one-cycle TIM stub.
module tb_tim_arbiter;
    logic        clock = 1'b0, reset = 1'b0;
    logic        imem_valid = 1'b0, dmem_valid = 1'b0;
    logic [31:0] imem_addr = '0, imem_wdata = '0, dmem_addr = '0, dmem_wdata = '0;
    logic [3:0]  imem_wstrb = '0, dmem_wstrb = '0;
    logic [31:0] imem_rdata, dmem_rdata, tim_addr, tim_wdata;
    logic [31:0] tim_rdata = '0;
    logic        imem_ready, dmem_ready, tim_valid, tim_instr;
    logic        tim_ready = 1'b0;
    logic [3:0]  tim_wstrb;
    logic [31:0] mem [256];
    logic        written [256];
    logic        busy_i = 1'b0, busy_d = 1'b0;
    int          errors = 0, checks = 0;

    tim_arbiter dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .tim_valid(tim_valid), .tim_instr(tim_instr), .tim_addr(tim_addr),
        .tim_wdata(tim_wdata), .tim_wstrb(tim_wstrb), .tim_rdata(tim_rdata),
        .tim_ready(tim_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] seed(input logic [7:0] idx);
        return (idx == 8'h10) ? 32'hDEADBEEF : {24'hC0DE00, idx};
    endfunction

    function automatic logic [31:0] rd_word(input logic [7:0] idx);
        return written[idx] ? mem[idx] : seed(idx);
    endfunction

    // TIM stub: one request per cycle, response exactly one cycle later
    always @(posedge clock) begin
        logic [7:0]  idx;
        logic [31:0] w;
        idx = tim_addr[9:2];
        w = rd_word(idx);
        tim_ready <= tim_valid;
        tim_rdata <= (tim_valid && tim_wstrb == 4'h0) ? w : 32'h0;
        if (tim_valid && tim_wstrb != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (tim_wstrb[b]) w[b*8 +: 8] = tim_wdata[b*8 +: 8];
            mem[idx]     <= w;
            written[idx] <= 1'b1;
        end
    end

    always @(posedge clock) begin
        busy_i <= reset & ((busy_i & ~imem_ready) | imem_valid);
        busy_d <= reset & ((busy_d & ~dmem_ready) | dmem_valid);
    end

    always @(negedge clock) begin
        if (reset) begin
            assert (!(imem_valid && busy_i && !imem_ready)) else $error("protocol: imem re-request while busy");
            assert (!(dmem_valid && busy_d && !dmem_ready)) else $error("protocol: dmem re-request while busy");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                         input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
        imem_valid = iv;
        imem_addr  = ia;
        dmem_valid = dv;
        dmem_addr  = da;
        dmem_wdata = dw;
        dmem_wstrb = ds;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic wi, wd, prev;
        int   si, sd, ci, cd;
        for (int i = 0; i < 256; i++) written[i] = 1'b0;
        drive(1, 32'h10, 1, 32'h20, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("rst_valid", {31'd0, tim_valid}, 0);
            check("rst_ready", {30'd0, imem_ready, dmem_ready}, 0);
            check("rst_addr", tim_addr, 0);
            check("rst_rdata", imem_rdata | dmem_rdata, 0);
        end
        tick;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        check("release_ready", {30'd0, imem_ready, dmem_ready}, 0);
        check("release_pend", {31'd0, tim_valid}, 0);

        tick;
        drive(1, 32'h40, 0, 0, 0, 0);
        check("fetch_valid", {31'd0, tim_valid}, 1);
        check("fetch_instr", {31'd0, tim_instr}, 1);
        check("fetch_addr", tim_addr, 32'h40);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        check("fetch_ready", {30'd0, imem_ready, dmem_ready}, 2);
        check("fetch_rdata", imem_rdata, 32'hDEADBEEF);

        tick;
        drive(1, 32'h10, 1, 32'h20, 0, 0);
        check("tie1_instr", {31'd0, tim_instr}, 0);
        check("tie1_addr", tim_addr, 32'h20);
        tick;
        drive(0, 0, 1, 32'h24, 0, 0);
        check("tie1_dready", {30'd0, imem_ready, dmem_ready}, 1);
        check("tie1_drdata", dmem_rdata, 32'hC0DE0008);
        check("tie1_irdata", imem_rdata, 0);
        check("tie2_instr", {31'd0, tim_instr}, 1);
        check("tie2_addr", tim_addr, 32'h10);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        check("tie2_iready", {30'd0, imem_ready, dmem_ready}, 2);
        check("tie2_irdata", imem_rdata, 32'hC0DE0004);
        check("tie2_drdata", dmem_rdata, 0);
        check("tie2_dissue", {tim_valid, tim_instr, tim_addr[29:0]}, {2'b10, 30'h24});
        tick;
        check("tie2_dready", {30'd0, imem_ready, dmem_ready}, 1);
        check("tie2_drdata2", dmem_rdata, 32'hC0DE0009);
        check("tie2_idle", {31'd0, tim_valid}, 0);

        tick;
        drive(0, 0, 1, 32'h80, 32'h12345678, 4'hF);
        check("st_wstrb", {28'd0, tim_wstrb}, 32'hF);
        check("st_wdata", tim_wdata, 32'h12345678);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        check("st_ready", {31'd0, dmem_ready}, 1);
        check("st_rdata", dmem_rdata, 0);
        tick;
        drive(0, 0, 1, 32'h80, 0, 0);
        check("ld_wstrb", {28'd0, tim_wstrb}, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        check("ld_ready", {31'd0, dmem_ready}, 1);
        check("ld_rdata", dmem_rdata, 32'h12345678);

        wi = 1; wd = 1; si = 0; sd = 0; ci = 0; cd = 0; prev = 0;
        for (int c = 0; c < 100 && (ci < 20 || cd < 20); c++) begin
            tick;
            imem_valid = wi && si < 20;
            dmem_valid = wd && sd < 20;
            imem_addr  = 32'h100;
            dmem_addr  = 32'h104;
            if (imem_valid) begin si++; wi = 0; end
            if (dmem_valid) begin sd++; wd = 0; end
            #1;
            if (c > 0 && c < 40) check("sus_valid", {31'd0, tim_valid}, 1);
            if (c > 0 && tim_valid) check("sus_alt", {31'd0, tim_instr}, {31'd0, ~prev});
            if (tim_valid) prev = tim_instr;
            if (imem_ready) begin ci++; wi = 1; check("sus_irdata", imem_rdata, 32'hC0DE0040); end
            if (dmem_ready) begin cd++; wd = 1; check("sus_drdata", dmem_rdata, 32'hC0DE0041); end
        end
        check("sus_icount", ci, 20);
        check("sus_dcount", cd, 20);

        tick;
        drive(1, 32'h40, 1, 32'h20, 0, 0);
        check("mid_issue", {30'd0, tim_valid, tim_instr}, 3);
        tick;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        check("mid_rst_ready", {30'd0, imem_ready, dmem_ready}, 0);
        check("mid_rst_valid", {31'd0, tim_valid}, 0);
        tick;
        reset = 1'b1;
        #1;
        check("mid_rel_ready", {30'd0, imem_ready, dmem_ready}, 0);
        check("mid_rel_pend", {31'd0, tim_valid}, 0);
        tick;
        check("mid_after", {29'd0, tim_valid, imem_ready, dmem_ready}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
